// File: rtl/spi_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : spi_rx_pkg                                                |
// | Purpose  : Shared state encoding and pin idle levels for spi_rx_byte |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package spi_rx_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_state_e;

   localparam logic SCLK_IDLE = 1'b0;
   localparam logic CS_N_IDLE = 1'b1;
   localparam logic MOSI_IDLE = 1'b0;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sync_edge_det                                             |
// | Purpose  : Pin synchroniser with registered level and edge pulses    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sync_edge_det
   import spi_rx_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_LEVEL   = 1'b0
) (
   input  logic clk,
   input  logic clr,
   input  logic i_din,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_edge;

   // o_level doubles as the previous value of r_edge, so level and pulses
   // leave this block on the same cycle and stay mutually aligned.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_sync  <= {SYNC_STAGES{RST_LEVEL}};
         r_edge  <= RST_LEVEL;
         o_level <= RST_LEVEL;
         o_rise  <= 1'b0;
         o_fall  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], i_din};
         r_edge  <= r_sync[SYNC_STAGES-1];
         o_level <= r_edge;
         o_rise  <= r_edge & ~o_level;
         o_fall  <= ~r_edge & o_level;
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_rx_byte.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : spi_rx_byte                                               |
// | Purpose  : SPI mode-0 slave receiver, MSB-first words + load strobe  |
// |            Optional frame-abort pulse: define SPI_RX_FRM_ERR_EN      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module spi_rx_byte
   import spi_rx_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic [DATA_W-1:0] q_data,
   output logic              ena,
   output logic              busy
`ifdef SPI_RX_FRM_ERR_EN
   ,
   output logic              frm_err
`endif
);

   localparam int              CNT_W      = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

   logic w_sclk_lvl, w_s_rise, w_s_fall;
   logic w_cs_lvl, w_cs_rise, w_cs_fall;
   logic w_mosi, w_mosi_rise, w_mosi_fall;
   logic w_unused;

   spi_state_e        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [DATA_W-1:0] r_sr;
   logic              w_shift;
   logic              w_word_done;

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_LEVEL(SCLK_IDLE)) u_sclk (
      .clk(clk), .clr(clr), .i_din(sclk),
      .o_level(w_sclk_lvl), .o_rise(w_s_rise), .o_fall(w_s_fall)
   );

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_LEVEL(CS_N_IDLE)) u_cs_n (
      .clk(clk), .clr(clr), .i_din(cs_n),
      .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
   );

   // Same pipeline depth as sclk, so w_mosi holds the bit present at the raw rise.
   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_LEVEL(MOSI_IDLE)) u_mosi (
      .clk(clk), .clr(clr), .i_din(mosi),
      .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
   );

   assign w_unused = &{1'b0, w_sclk_lvl, w_s_fall, w_cs_lvl, w_mosi_rise, w_mosi_fall};

   always_comb begin
      w_shift     = (r_state == SHIFT) && w_s_rise;
      w_word_done = w_shift && (r_cnt == C_CNT_LAST);
      w_cnt_nxt   = r_cnt;
      if (w_shift) begin
         w_cnt_nxt = w_word_done ? '0 : r_cnt + C_CNT_ONE;
      end
   end

   // A same-cycle sclk rise is applied before a cs_n rise closes the frame.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_sr    <= '0;
         q_data  <= '0;
         ena     <= 1'b0;
`ifdef SPI_RX_FRM_ERR_EN
         frm_err <= 1'b0;
`endif
      end else begin
         ena <= 1'b0;
`ifdef SPI_RX_FRM_ERR_EN
         frm_err <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (w_cs_fall) begin
                  r_cnt   <= '0;
                  r_sr    <= '0;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (w_shift) begin
                  r_sr  <= {r_sr[DATA_W-2:0], w_mosi};
                  r_cnt <= w_cnt_nxt;
               end
               if (w_word_done) begin
                  q_data <= {r_sr[DATA_W-2:0], w_mosi};
                  ena    <= 1'b1;
               end
               if (w_cs_rise) begin
                  r_state <= IDLE;
`ifdef SPI_RX_FRM_ERR_EN
                  frm_err <= (w_cnt_nxt != '0);
`endif
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy = (r_state == SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_spi_rx_byte.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_spi_rx_byte                                            |
// | Purpose  : Self-checking bench, SYNC_STAGES=2 and =3 DUTs in parallel|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_spi_rx_byte;

   localparam int W  = 8;
   localparam int PH = 4;

   logic clk = 1'b0;
   logic clr, sclk, cs_n, mosi;
   logic [W-1:0] q2, q3;
   logic ena2, ena3, busy2, busy3;
`ifdef SPI_RX_FRM_ERR_EN
   logic fe2, fe3;
`endif

   spi_rx_byte #(.DATA_W(W), .SYNC_STAGES(2)) dut2 (
      .clk(clk), .clr(clr), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .q_data(q2), .ena(ena2), .busy(busy2)
`ifdef SPI_RX_FRM_ERR_EN
      , .frm_err(fe2)
`endif
   );

   spi_rx_byte #(.DATA_W(W), .SYNC_STAGES(3)) dut3 (
      .clk(clk), .clr(clr), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .q_data(q3), .ena(ena3), .busy(busy3)
`ifdef SPI_RX_FRM_ERR_EN
      , .frm_err(fe3)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observed strobes, stamped with the cycle count at the following negedge
   int           ena_cyc2[$], ena_cyc3[$];
   logic [W-1:0] ena_dat2[$], ena_dat3[$];
   int           fe_cnt2 = 0, fe_cnt3 = 0;
   always @(negedge clk) begin
      if (ena2 === 1'b1) begin ena_cyc2.push_back(cyc); ena_dat2.push_back(q2); end
      if (ena3 === 1'b1) begin ena_cyc3.push_back(cyc); ena_dat3.push_back(q3); end
`ifdef SPI_RX_FRM_ERR_EN
      if (fe2 === 1'b1) fe_cnt2 <= fe_cnt2 + 1;
      if (fe3 === 1'b1) fe_cnt3 <= fe_cnt3 + 1;
`endif
   end

   // Reference: every W-th bit of a frame completes a word; its strobe is due
   // SYNC_STAGES+2 edges after the edge that samples that bit's sclk rise.
   int           exp_cyc[$];
   logic [W-1:0] exp_dat[$];
   int           exp_fe = 0;
   int           vi2 = 0, vi3 = 0;
   int           checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b, output int rise);
      mosi = b;
      repeat (PH) @(negedge clk);
      sclk = 1'b1;
      rise = cyc + 1;
      repeat (PH) @(negedge clk);
      sclk = 1'b0;
   endtask

   task automatic frame(input string tag, input int nbits, input logic [63:0] v, input bit collide);
      logic [W-1:0] word;
      logic         b;
      int           rise;
      word = '0;
      cs_n = 1'b0;
      repeat (PH) @(negedge clk);
      for (int i = 1; i <= nbits; i++) begin
         b    = v[nbits-i];
         word = {word[W-2:0], b};
         mosi = b;
         repeat (PH) @(negedge clk);
         sclk = 1'b1;
         rise = cyc + 1;
         if (i % W == 0) begin
            exp_cyc.push_back(rise);
            exp_dat.push_back(word);
         end
         if (collide && i == nbits) cs_n = 1'b1;
         repeat (PH) @(negedge clk);
         sclk = 1'b0;
         if (i == 1) begin
            chk({tag, "_busy2_mid"}, 32'(busy2), 32'd1);
            chk({tag, "_busy3_mid"}, 32'(busy3), 32'd1);
         end
      end
      if (nbits % W != 0) exp_fe++;
      repeat (PH) @(negedge clk);
      cs_n = 1'b1;
      repeat (16) @(negedge clk);
      chk({tag, "_busy2_end"}, 32'(busy2), 32'd0);
      chk({tag, "_busy3_end"}, 32'(busy3), 32'd0);
   endtask

   task automatic verify(input string tag);
      chk({tag, "_nwords2"}, ena_cyc2.size(), exp_cyc.size());
      chk({tag, "_nwords3"}, ena_cyc3.size(), exp_cyc.size());
      while (vi2 < exp_cyc.size() && vi2 < ena_cyc2.size()) begin
         chk({tag, "_data2"}, 32'(ena_dat2[vi2]), 32'(exp_dat[vi2]));
         chk({tag, "_lat2"}, ena_cyc2[vi2], exp_cyc[vi2] + 4);
         vi2++;
      end
      while (vi3 < exp_cyc.size() && vi3 < ena_cyc3.size()) begin
         chk({tag, "_data3"}, 32'(ena_dat3[vi3]), 32'(exp_dat[vi3]));
         chk({tag, "_lat3"}, ena_cyc3[vi3], exp_cyc[vi3] + 5);
         vi3++;
      end
      if (exp_dat.size() > 0) begin
         chk({tag, "_hold2"}, 32'(q2), 32'(exp_dat[$]));
         chk({tag, "_hold3"}, 32'(q3), 32'(exp_dat[$]));
      end
`ifdef SPI_RX_FRM_ERR_EN
      chk({tag, "_frmerr2"}, fe_cnt2, exp_fe);
      chk({tag, "_frmerr3"}, fe_cnt3, exp_fe);
`endif
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_q2"}, 32'(q2), 32'd0);
      chk({tag, "_q3"}, 32'(q3), 32'd0);
      chk({tag, "_ena2"}, 32'(ena2), 32'd0);
      chk({tag, "_ena3"}, 32'(ena3), 32'd0);
      chk({tag, "_busy2"}, 32'(busy2), 32'd0);
      chk({tag, "_busy3"}, 32'(busy3), 32'd0);
`ifdef SPI_RX_FRM_ERR_EN
      chk({tag, "_fe2"}, 32'(fe2), 32'd0);
      chk({tag, "_fe3"}, 32'(fe3), 32'd0);
`endif
   endtask

   initial begin
      int rise;
      int nb;
      logic [63:0] rv;

      clr = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      clr = 1'b0;
      repeat (6) @(negedge clk);

      // Single word with exact busy onset: cs_n low sampled on edge k+1
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
      chk("busy2_pre", 32'(busy2), 32'd0);
      chk("busy3_pre", 32'(busy3), 32'd0);
      @(negedge clk);
      chk("busy2_on", 32'(busy2), 32'd1);
      chk("busy3_pre2", 32'(busy3), 32'd0);
      @(negedge clk);
      chk("busy3_on", 32'(busy3), 32'd1);
      frame("single", 8, 64'hA5, 1'b0);
      verify("single");

      frame("b2b", 16, 64'h3CC3, 1'b0);
      verify("b2b");

      frame("abort", 5, 64'h16, 1'b0);
      verify("abort");
      chk("abort_q2", 32'(q2), 32'hC3);

      frame("collide", 8, 64'h5A, 1'b1);
      verify("collide");

      // Reset mid-frame with cs_n still low; the next frame starts on release
      cs_n = 1'b0;
      repeat (PH) @(negedge clk);
      for (int i = 0; i < 3; i++) send_bit(1'b1, rise);
      clr = 1'b1;
      @(negedge clk);
      chk_zero("midreset");
      repeat (3) @(negedge clk);
      clr = 1'b0;
      frame("postreset", 8, 64'h81, 1'b0);
      verify("postreset");

      for (int f = 0; f < 6; f++) begin
         nb = int'($urandom_range(1, 24));
         rv = {$urandom, $urandom};
         frame("rand", nb, rv, 1'(f % 2));
         verify("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/spi_rx_byte.md
# spi_rx_byte

SPI mode-0 slave receive front end: synchronises raw `sclk`/`cs_n`/`mosi` pins into the `clk` domain, shifts in MSB-first words and emits each completed word with a one-cycle load strobe. It sits directly upstream of the slave's DFFE-based register bank. `q_data` drives the flops' `d` inputs and `ena` drives their `ena` inputs, so each completed word is captured on the next `clk` edge.

## Interface
- `DATA_W`, default 8: word width in bits; legal range 2 to 32.
- `SYNC_STAGES`, default 2: synchroniser depth for the pin inputs; legal range 2 to 3.
- `clk`, input, 1: system clock; all logic on its rising edge.
- `clr`, input, 1: reset, synchronous, active-high.
- `sclk`, input, 1: raw SPI clock, asynchronous to `clk`.
- `cs_n`, input, 1: raw chip select, active-low, asynchronous.
- `mosi`, input, 1: raw serial data, asynchronous.
- `q_data`, output, `DATA_W`: last completed word; held until the next word completes.
- `ena`, output, 1: one-cycle strobe marking `q_data` as new.
- `busy`, output, 1: high while in state `SHIFT`.
- `frm_err`, output, 1: exists only with `SPI_RX_FRM_ERR_EN`; one-cycle abort pulse.

## Operation
- **Synchronisation.** Each pin passes through a `SYNC_STAGES`-deep flop chain.
- **Edge detection.** `sclk` and `cs_n` each get one further register for edge detection.
  - `sclk` rising edge is `s_rise`.
  - `cs_n` falling edge is `cs_fall`; `cs_n` rising edge is `cs_rise`.
- **`mosi` alignment.** `mosi` is delayed to match, so the bit sampled on `s_rise` is the value present at the raw `sclk` rise.
- **Bit counter.** `cnt` is `$clog2(DATA_W)` bits wide.
- **State `IDLE`.**
  - `cs_fall` clears `cnt` and the shift register, then moves to `SHIFT`.
  - `sclk` edges are ignored.
- **State `SHIFT`.** On each `s_rise`:
  - shift `mosi` into the LSB of `sr` (MSB-first transfer);
  - increment `cnt`.
- **Word completion.** When `s_rise` occurs with `cnt == DATA_W-1`:
  - `q_data <= {sr[DATA_W-2:0], mosi}`;
  - `ena <= 1`;
  - `cnt` wraps to 0;
  - stay in `SHIFT`, so back-to-back words work within one `cs_n` frame.
- **Leaving `SHIFT`.** `cs_rise` returns to `IDLE`. A partial word is discarded and `q_data` is unchanged.
- **Simultaneous `s_rise` and `cs_rise`.** The `sclk` edge is processed first: the shift happens, any word completion and `ena` fire, then the state goes to `IDLE`.
- **Reset.** `clr` high:
  - `q_data=0`, `ena=0`, `busy=0`, `frm_err=0`, `cnt=0`, `sr=0`, state `IDLE`;
  - synchronisers load the idle levels `sclk=0`, `cs_n=1`, `mosi=0`.
- **Reset in mid-frame.** The frame is abandoned. Because the `cs_n` synchroniser reloads to 1, a still-low `cs_n` produces one `cs_fall` once `clr` releases, and the next frame starts there. The bench treats bits already shifted before reset as undefined.
- **`ena` in `IDLE`.** `ena` is never asserted in `IDLE`.

## Timing
- **Latency.** `ena` and the new `q_data` appear together, `SYNC_STAGES+2` `clk` edges after the first `clk` edge that samples the final raw `sclk` rise.
- **Strobe width.** `ena` is exactly one `clk` cycle wide.
- **Downstream capture.** The downstream DFFE captures `q_data` on the edge that ends the `ena` cycle.
- **Minimum pin widths.**
  - `sclk` high and low phases: each ≥ `SYNC_STAGES+1` `clk` periods.
  - `cs_n` high time: ≥ `SYNC_STAGES+1` `clk` periods.
  - Narrower pulses are unsupported and may be missed.
- **Input timing.** `mosi` must be stable around the raw `sclk` rise, as SPI mode 0 requires.
- **Output registration.** All outputs are registered; no combinational path from any pin to an output.

## Configuration
- **Macro:** `SPI_RX_FRM_ERR_EN`.
- **Defined:**
  - `frm_err` port exists.
  - `frm_err` pulses high for one `clk` cycle on the edge where `SHIFT` exits to `IDLE` with a partial word pending: `cnt != 0` after processing any same-cycle `s_rise`.
  - `frm_err` resets to 0.
- **Undefined:** the port is absent and partial words are discarded silently. All other behaviour is identical.

## Structure
- **Package `spi_rx_pkg`:**
  - state enum (`IDLE`, `SHIFT`);
  - idle-level constants `SCLK_IDLE=0`, `CS_N_IDLE=1`, `MOSI_IDLE=0`.
- **Sub-module `sync_edge_det`:**
  - parameters: `SYNC_STAGES` and reset level;
  - outputs: synced level, rise pulse, fall pulse;
  - one instance each for `sclk` and `cs_n`;
  - `mosi` uses the same module with its edge outputs unused.

## Test plan
- **Single word.** `DATA_W=8`, `cs_n` low, shift 0xA5 MSB-first, `cs_n` high. Expect exactly one `ena` pulse with `q_data=0xA5`; `busy` high from `cs_fall`+1 until `cs_rise`+1.
- **Back-to-back words.** One frame carrying 0x3C then 0xC3. Expect two `ena` pulses, `q_data=0x3C` then `0xC3`, with `q_data` held between them.
- **Aborted word.** 5 bits, then `cs_n` high. Expect no `ena` and `q_data` unchanged. With `SPI_RX_FRM_ERR_EN`, expect one `frm_err` pulse.
- **Same-edge collision.** 8th `sclk` rise and `cs_n` rise reach the edge detectors on the same `clk`. Expect `ena` with the full word, no `frm_err`, state `IDLE`.
- **Reset mid-frame.** Assert `clr` after 3 bits with `cs_n` held low. Expect all outputs 0 during reset. After release, a fresh 8-bit 0x81 yields `q_data=0x81`.
- **Latency check.** `SYNC_STAGES=3`, minimum-width `sclk` phases of 4 `clk` periods. Expect `ena` exactly 5 `clk` edges after the sampling edge of the final `sclk` rise, with no missed bits.
